// File: rtl/neopixel_pkg.sv
// Shared state encoding, pixel geometry and GRB field offsets for the
// WS2812-style strip controller.
package neopixel_pkg;

  localparam int PIXEL_W   = 24;
  localparam int G_LSB     = 16;
  localparam int R_LSB     = 8;
  localparam int B_LSB     = 0;
  localparam int BIT_CNT_W = $clog2(PIXEL_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  function automatic logic [PIXEL_W-1:0] pack_grb(input logic [7:0] g,
                                                   input logic [7:0] r,
                                                   input logic [7:0] b);
    logic [PIXEL_W-1:0] p;
    p = '0;
    p[G_LSB +: 8] = g;
    p[R_LSB +: 8] = r;
    p[B_LSB +: 8] = b;
    return p;
  endfunction

endpackage

// File: rtl/neopixel_bit_gen.sv
// Per-bit waveform timer: one start strobe launches a T_BIT-cycle bit whose
// high phase lasts T0H or T1H cycles depending on bit_val.
module neopixel_bit_gen #(
  parameter int T0H   = 10,
  parameter int T1H   = 19,
  parameter int T_BIT = 34
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_val,
  output logic line,
  output logic high_end,
  output logic bit_done
);

  localparam int CNT_W = $clog2(T_BIT);

  logic [CNT_W-1:0] cnt_reg;
  logic             running_reg;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] high_last;

  // bit_val must stay stable for the whole bit; the caller holds it in a shift register
  assign high_len  = bit_val ? CNT_W'(T1H)     : CNT_W'(T0H);
  assign high_last = bit_val ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);

  assign line     = running_reg && (cnt_reg < high_len);
  assign high_end = running_reg && (cnt_reg == high_last);
  assign bit_done = running_reg && (cnt_reg == CNT_W'(T_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      running_reg <= 1'b0;
    end else if (start) begin
      cnt_reg     <= '0;
      running_reg <= 1'b1;
    end else if (bit_done) begin
      cnt_reg     <= '0;
      running_reg <= 1'b0;
    end else if (running_reg) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/neopixel_strip_ctrl.sv
// WS2812 strip controller: frame buffer of GRB pixels, serialised MSB-first
// with a latch gap after each frame; single frames or continuous refresh.
module neopixel_strip_ctrl
  import neopixel_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int ADDR_W     = 8,
  parameter int T0H        = 10,
  parameter int T1H        = 19,
  parameter int T_BIT      = 34,
  parameter int T_RESET    = 1400,
  parameter bit INVERT_OUT = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic                i_wr_en,
  input  logic [PIXEL_W-1:0]  i_wr_data,
  input  logic                i_start,
  input  logic                i_auto,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_led_out
);

  localparam int IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LATCH_W = $clog2(T_RESET);

  logic [PIXEL_W-1:0] pix_arr [NUM_LEDS];

  // Out-of-range addresses match no pixel, so those writes simply vanish
  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_pix
      logic [PIXEL_W-1:0] pix_reg;

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          pix_reg <= '0;
        end else if (i_wr_en && (i_wr_addr == ADDR_W'(gi))) begin
          pix_reg <= i_wr_data;
        end
      end

      assign pix_arr[gi] = pix_reg;
    end
  endgenerate

  state_t               state_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic [PIXEL_W-1:0]   shift_reg;
  logic [LATCH_W-1:0]   latch_cnt_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 led_reg;

  logic gen_start;
  logic gen_line;
  logic gen_high_end;
  logic gen_bit_done;
  logic more_bits;

  assign more_bits = (bit_cnt_reg != '0);
  assign gen_start = (state_reg == ST_LOAD) ||
                     ((state_reg == ST_LOW) && gen_bit_done && more_bits);

  neopixel_bit_gen #(
    .T0H   (T0H),
    .T1H   (T1H),
    .T_BIT (T_BIT)
  ) u_bit_gen (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .start    (gen_start),
    .bit_val  (shift_reg[PIXEL_W-1]),
    .line     (gen_line),
    .high_end (gen_high_end),
    .bit_done (gen_bit_done)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      latch_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      led_reg       <= INVERT_OUT;
    end else begin
      done_reg <= 1'b0;
      // Line is registered one cycle behind the state so the pin never glitches
      led_reg  <= gen_line ^ INVERT_OUT;
      case (state_reg)
        ST_IDLE: begin
          if (i_start || i_auto) begin
            state_reg <= ST_LOAD;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_LOAD: begin
          shift_reg   <= pix_arr[idx_reg];
          bit_cnt_reg <= BIT_CNT_W'(PIXEL_W - 1);
          state_reg   <= ST_HIGH;
        end
        ST_HIGH: begin
          if (gen_high_end) begin
            state_reg <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (gen_bit_done) begin
            if (more_bits) begin
              shift_reg   <= {shift_reg[PIXEL_W-2:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg - BIT_CNT_W'(1);
              state_reg   <= ST_HIGH;
            end else if (idx_reg < IDX_W'(NUM_LEDS - 1)) begin
              idx_reg   <= idx_reg + IDX_W'(1);
              state_reg <= ST_LOAD;
            end else begin
              latch_cnt_reg <= '0;
              state_reg     <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          if (latch_cnt_reg == LATCH_W'(T_RESET - 1)) begin
            latch_cnt_reg <= '0;
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
          end else begin
            latch_cnt_reg <= latch_cnt_reg + LATCH_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = busy_reg;
  assign o_done    = done_reg;
  assign o_led_out = led_reg;

endmodule

// File: tb/tb_neopixel_strip_ctrl.sv
// Bench for neopixel_strip_ctrl: table of frames plus random pixels/writes,
// checked cycle by cycle against a waveform model built from the bit rules.
`timescale 1ns/1ps
module tb_neopixel_strip_ctrl;
  import neopixel_pkg::*;

  localparam int NL = 2;
  localparam int AW = 2;
  localparam int T0 = 3;
  localparam int T1 = 6;
  localparam int TB = 9;
  localparam int TR = 20;
  localparam int PIX_SPAN    = 24 * TB;
  localparam int LOAD_STRIDE = PIX_SPAN + 1;
  // Edge (counted from the edge that samples the request) at which done rises
  localparam int DONE_EDGE   = 1 + NL * PIX_SPAN + (NL - 1) + TR;
  localparam int NVEC        = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [23:0]   wr_data;
  logic          start;
  logic          auto_en;
  logic          busy;
  logic          done;
  logic          led;

  int checks   = 0;
  int failures = 0;

  neopixel_strip_ctrl #(
    .NUM_LEDS   (NL),
    .ADDR_W     (AW),
    .T0H        (T0),
    .T1H        (T1),
    .T_BIT      (TB),
    .T_RESET    (TR),
    .INVERT_OUT (1'b1)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_wr_addr (wr_addr),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_start   (start),
    .i_auto    (auto_en),
    .o_busy    (busy),
    .o_done    (done),
    .o_led_out (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pre_en0;
    logic [AW-1:0] pre_a0;
    logic [23:0]   pre_d0;
    logic          pre_en1;
    logic [AW-1:0] pre_a1;
    logic [23:0]   pre_d1;
    int            wr_at;
    logic [AW-1:0] wr_a;
    logic [23:0]   wr_d;
    int            restart_at;
    logic [23:0]   exp0;
    logic [23:0]   exp1;
  } vec_t;

  vec_t        vecs [NVEC];
  logic [23:0] mbuf [NL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: frame buffer contents plus the rule that pixel p is captured
  // at the edge ending its LOAD cycle (edge 1 + p*LOAD_STRIDE).
  function automatic void model_frame(input vec_t v, output logic [23:0] s0, output logic [23:0] s1);
    logic [23:0] snap [NL];
    if (v.pre_en0 && int'(v.pre_a0) < NL) mbuf[int'(v.pre_a0)] = v.pre_d0;
    if (v.pre_en1 && int'(v.pre_a1) < NL) mbuf[int'(v.pre_a1)] = v.pre_d1;
    for (int p = 0; p < NL; p++) begin
      snap[p] = mbuf[p];
      if (v.wr_at > 0 && int'(v.wr_a) == p && v.wr_at <= p * LOAD_STRIDE) snap[p] = v.wr_d;
    end
    if (v.wr_at > 0 && int'(v.wr_a) < NL) mbuf[int'(v.wr_a)] = v.wr_d;
    s0 = snap[0];
    s1 = snap[1];
  endfunction

  // Logical line expected just after edge c of a frame carrying p0 then p1
  function automatic logic exp_line(input int c, input logic [23:0] p0, input logic [23:0] p1);
    int t, b, ph;
    logic [23:0] px;
    if (c < 2) return 1'b0;
    t = c - 2;
    if (t < PIX_SPAN) begin
      px = p0;
    end else if (t < LOAD_STRIDE) begin
      return 1'b0;
    end else if (t < LOAD_STRIDE + PIX_SPAN) begin
      px = p1;
      t  = t - LOAD_STRIDE;
    end else begin
      return 1'b0;
    end
    b  = t / TB;
    ph = t % TB;
    return (ph < (px[23 - b] ? T1 : T0));
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [23:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Request (start or auto) must already be driven; it is sampled at the next edge
  task automatic run_frame(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                           input int wr_at, input logic [AW-1:0] wr_a, input logic [23:0] wr_d,
                           input int restart_at, input int drop_auto_at);
    int line_err = 0;
    int busy_err = 0;
    int done_cnt = 0;
    int done_at  = -1;
    int first_bad = -1;
    for (int c = 0; c <= DONE_EDGE; c++) begin
      @(posedge clk); #1;
      start = (c + 1 == restart_at);
      wr_en = (c + 1 == wr_at);
      if (wr_en) begin
        wr_addr = wr_a;
        wr_data = wr_d;
      end
      if (c + 1 == drop_auto_at) auto_en = 1'b0;
      @(negedge clk);
      if ((led ^ 1'b1) !== exp_line(c, e0, e1)) begin
        line_err++;
        if (first_bad < 0) first_bad = c;
      end
      if (busy !== (c < DONE_EDGE)) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
    end
    check($sformatf("%s line_errors(first at edge %0d)", tag, first_bad), line_err, 0);
    check({tag, " busy_errors"}, busy_err, 0);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_edge"}, done_at, DONE_EDGE);
    $display("frame %s: pix0=%06h pix1=%06h line_err=%0d done_at=%0d", tag, e0, e1, line_err, done_at);
  endtask

  task automatic idle_check(input string tag, input int n);
    int err = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || led !== 1'b1) err++;
    end
    check({tag, " idle_errors"}, err, 0);
  endtask

  function automatic vec_t mk(input logic e0, input logic [AW-1:0] a0, input logic [23:0] d0,
                              input logic e1, input logic [AW-1:0] a1, input logic [23:0] d1,
                              input int wat, input logic [AW-1:0] wa, input logic [23:0] wd,
                              input int rs, input logic [23:0] x0, input logic [23:0] x1);
    vec_t v;
    v.pre_en0 = e0; v.pre_a0 = a0; v.pre_d0 = d0;
    v.pre_en1 = e1; v.pre_a1 = a1; v.pre_d1 = d1;
    v.wr_at = wat; v.wr_a = wa; v.wr_d = wd;
    v.restart_at = rs; v.exp0 = x0; v.exp1 = x1;
    return v;
  endfunction

  initial begin
    logic [23:0] s0, s1;
    rst_n = 1'b0; wr_addr = '0; wr_en = 1'b0; wr_data = '0; start = 1'b0; auto_en = 1'b0;
    for (int p = 0; p < NL; p++) mbuf[p] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset led_out", led, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed entries with hand-derived snapshots
    vecs[0] = mk(1, 2'd0, pack_grb(8'hAA, 8'h00, 8'h00), 1, 2'd1, 24'h000001,
                 -1, 2'd0, 24'h0, 440, 24'hAA0000, 24'h000001);
    vecs[1] = mk(0, 2'd0, 24'h0, 0, 2'd0, 24'h0,
                 300, 2'd0, 24'h123456, 453, 24'hAA0000, 24'h000001);
    vecs[2] = mk(0, 2'd0, 24'h0, 0, 2'd0, 24'h0,
                 -1, 2'd0, 24'h0, -1, 24'h123456, 24'h000001);
    vecs[3] = mk(0, 2'd0, 24'h0, 0, 2'd0, 24'h0,
                 100, 2'd1, 24'h00FF00, -1, 24'h123456, 24'h00FF00);
    vecs[4] = mk(1, 2'd3, 24'hFFFFFF, 1, 2'd2, 24'h0F0F0F,
                 50, 2'd2, 24'hABCDEF, -1, 24'h123456, 24'h00FF00);
    for (int i = 0; i < 5; i++) model_frame(vecs[i], s0, s1);
    // Random pixels and a random mid-frame write, before or after pix1's load
    for (int i = 5; i < NVEC; i++) begin
      int wat;
      wat = ($urandom_range(0, 1) == 0) ? int'($urandom_range(3, 210)) : int'($urandom_range(222, 430));
      vecs[i] = mk(1, 2'd0, 24'($urandom), 1, 2'd1, 24'($urandom),
                   wat, 2'($urandom_range(0, 3)), 24'($urandom), -1, 24'h0, 24'h0);
      model_frame(vecs[i], s0, s1);
      vecs[i].exp0 = s0;
      vecs[i].exp1 = s1;
    end

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].pre_en0) wr(vecs[i].pre_a0, vecs[i].pre_d0);
      if (vecs[i].pre_en1) wr(vecs[i].pre_a1, vecs[i].pre_d1);
      @(posedge clk); #1;
      start = 1'b1;
      run_frame($sformatf("vec%0d", i), vecs[i].exp0, vecs[i].exp1,
                vecs[i].wr_at, vecs[i].wr_a, vecs[i].wr_d, vecs[i].restart_at, -1);
      idle_check($sformatf("vec%0d post", i), 25);
    end

    // Continuous refresh: three back-to-back frames, auto dropped during the third
    @(posedge clk); #1;
    auto_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      vec_t blank;
      blank = mk(0, 2'd0, 24'h0, 0, 2'd0, 24'h0, -1, 2'd0, 24'h0, -1, 24'h0, 24'h0);
      model_frame(blank, s0, s1);
      run_frame($sformatf("auto%0d", f), s0, s1, -1, 2'd0, 24'h0, -1, (f == 2) ? 100 : -1);
    end
    idle_check("auto stop", 30);

    // Reset during the high phase of the first bit
    wr(2'd0, pack_grb(8'hFF, 8'hFF, 8'hFF));
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    check("pre_reset line_high", led, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset led_out", led, 1);
    check("async_reset busy", busy, 0);
    check("async_reset done", done, 0);
    for (int p = 0; p < NL; p++) mbuf[p] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_check("after reset", 20);

    wr(2'd3, 24'hFFFFFF);
    @(posedge clk); #1;
    start = 1'b1;
    run_frame("cleared", mbuf[0], mbuf[1], -1, 2'd0, 24'h0, -1, -1);
    idle_check("cleared post", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neopixel_strip_ctrl.md
NEOPIXEL_STRIP_CTRL -- requirements
Module: neopixel_strip_ctrl

Interface
REQ-001 Parameter NUM_LEDS, default 8: number of pixels in the chain (1..256).
REQ-002 Parameter ADDR_W, default 8: pixel address width, with 2**ADDR_W >= NUM_LEDS.
REQ-003 Parameter T0H, default 10: high time of a 0 bit, in clock cycles.
REQ-004 Parameter T1H, default 19: high time of a 1 bit, in clock cycles; T0H < T1H < T_BIT.
REQ-005 Parameter T_BIT, default 34: total bit period, in clock cycles.
REQ-006 Parameter T_RESET, default 1400: latch (low) gap after a frame, in clock cycles.
REQ-007 Parameter INVERT_OUT, default 1: when 1, o_led_out is driven inverted for an inverting level shifter.
REQ-008 i_clk  in  1  sole clock.
REQ-009 i_reset  in  1  asynchronous, active-low reset.
REQ-010 i_wr_addr  in  ADDR_W  frame-buffer pixel address.
REQ-011 i_wr_en  in  1  frame-buffer write strobe.
REQ-012 i_wr_data  in  24  pixel colour in GRB order; G in bits [23:16].
REQ-013 i_start  in  1  request to transmit one frame.
REQ-014 i_auto  in  1  refresh continuously while high.
REQ-015 o_busy  out  1  a frame or latch gap is in progress.
REQ-016 o_done  out  1  one-cycle pulse at frame completion.
REQ-017 o_led_out  out  1  serial data line.

Function
REQ-018 Frame buffer: NUM_LEDS x 24-bit registers; a write occurs on any cycle with i_wr_en=1, busy or not; a write with i_wr_addr >= NUM_LEDS is ignored.
REQ-019 FSM states: IDLE, LOAD, HIGH, LOW, LATCH.
- IDLE -> LOAD when (i_start | i_auto) = 1; pixel index = 0.
- LOAD: 1 cycle; copies buffer[index] into a 24-bit shift register; bit count = 23.
- HIGH -> LOW after T0H or T1H cycles, according to the current bit.
- LOW -> HIGH for the next bit; a bit occupies exactly T_BIT cycles in HIGH+LOW combined.
- After bit 0: go to LOAD if index < NUM_LEDS-1 (index+1), otherwise go to LATCH.
- LATCH -> IDLE after T_RESET cycles.
REQ-020 Bits are sent MSB-first (G7 first); pixel 0 is sent first.
REQ-021 Tearing rule: a pixel is snapshotted in its LOAD cycle; a write to a pixel already loaded takes effect in the next frame; a write to a pixel not yet loaded takes effect in this frame.
REQ-022 Latency: i_start sampled high at edge k -> LOAD during cycle k+1 -> line first high (logical) at edge k+2.
REQ-023 The inter-pixel LOAD cycle extends the preceding LOW by exactly 1 cycle (tolerated by the WS2812 spec); no other gaps are inserted.
REQ-024 o_busy = 1 in every state except IDLE; i_start while busy is ignored and is not queued.
REQ-025 o_done is high for exactly the one cycle in which the FSM transitions LATCH -> IDLE.
REQ-026 With i_auto=1 in IDLE, the next frame begins the cycle after o_done; when i_auto falls mid-frame, the current frame and latch complete normally.
REQ-027 Logical line is low in IDLE, LOW and LATCH, and high in HIGH; o_led_out = logical line XOR INVERT_OUT, registered (no combinational glitches).
REQ-028 Counters are sized by $clog2 of their maximum parameter value; no counter wraps within a frame.

Reset
REQ-029 While i_reset=0: FSM=IDLE, all counters 0, shift register 0, o_busy=0, o_done=0, o_led_out=INVERT_OUT (logical low); the frame buffer is cleared to 0.
REQ-030 Reset asserted mid-frame aborts the frame immediately; after release the block waits in IDLE for a new request.

Structure
REQ-031 Package neopixel_pkg holds the FSM state encoding, PIXEL_W=24 and the GRB field offsets.
REQ-032 One sub-module, neopixel_bit_gen, holds the per-bit HIGH/LOW timing counter: it takes the bit value and a start strobe, and returns the logical line level and a bit-done strobe.

Verification
REQ-033 Bench parameters for all scenarios: NUM_LEDS=2, T0H=3, T1H=6, T_BIT=9, T_RESET=20.
REQ-034 Write pix0=24'hAA0000, pix1=24'h000001, pulse i_start -> 48 bits: pix0 high times 6,3,6,3,... (MSB-first); pix1 last bit 6; o_done after 2+48*9+1+20 cycles.
REQ-035 Pulse i_start again during LATCH -> ignored; exactly one o_done; line stays idle afterward.
REQ-036 Rewrite pix0 during pix1 transmission -> current frame unchanged; next frame sends the new pix0.
REQ-037 Hold i_auto=1 for 3 frames -> 3 o_done pulses, each new LOAD the cycle after o_done; drop i_auto -> the frame in flight completes, then IDLE.
REQ-038 Assert i_reset=0 mid-bit (HIGH) -> o_led_out=1 (INVERT_OUT=1) asynchronously, o_busy=0; write to address 3 -> ignored.
